uart_pro_tx: RTL and testbench

- Response formatter for the UART command protocol; the transmit-side counterpart of the command parser.
- Takes a one-cycle response request and serialises an ASCII response frame one byte at a time into the UART byte transmitter, using a start/done handshake.
- Frame types:
  - read response: "D AA HHHHHHHH\r\n"
  - write acknowledge: "OK\r\n"
  - failure: "ER\r\n"

---
 rtl/uart_pro_tx_if.sv | 25 ++
 rtl/uart_pro_tx.sv | 118 +++++++++++
 tb/tb_uart_pro_tx.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pro_tx_if.sv
// Response-formatter interface: request side (parser) and byte-transmitter side.
// REQ_* and TX_DONE are single-cycle pulses; TX_START strobes for one cycle and TX_DATA stays valid until the matching TX_DONE.
interface uart_pro_tx_if;
    logic        REQ_READ;
    logic        REQ_WRITE;
    logic        REQ_FAIL;
    logic [15:0] REQ_ADDR;
    logic [31:0] RD_DATA;
    logic        TX_DONE;
    logic [7:0]  TX_DATA;
    logic        TX_START;
    logic        BUSY;
    logic        FRAME_DONE;
    logic        TIMEOUT_ERR;

    modport master (
        output REQ_READ, REQ_WRITE, REQ_FAIL, REQ_ADDR, RD_DATA, TX_DONE,
        input  TX_DATA, TX_START, BUSY, FRAME_DONE, TIMEOUT_ERR
    );

    modport slave (
        input  REQ_READ, REQ_WRITE, REQ_FAIL, REQ_ADDR, RD_DATA, TX_DONE,
        output TX_DATA, TX_START, BUSY, FRAME_DONE, TIMEOUT_ERR
    );
endinterface

// File: rtl/uart_pro_tx.sv
// ASCII response formatter: builds a read/OK/ER frame on request and feeds it
// byte by byte to the UART transmitter with a start/done handshake and timeout.
module uart_pro_tx #(
    parameter logic [15:0] DONE_TIMEOUT = 16'd50000
) (
    input  logic          CLK,
    input  logic          RST,
    uart_pro_tx_if.slave  bus,
    output logic [1:0]    fsm_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2, FINISH = 2'd3} state_t;

    state_t         state;
    logic [119:0]   frame;
    logic [3:0]     count;
    logic [15:0]    tcnt;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           busy;
    logic           frame_done;
    logic           timeout_err;

    logic           accept;
    logic [119:0]   sel_frame;
    logic [3:0]     sel_count;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Frames are left-justified so the byte on the wire is always frame[119:112].
    always_comb begin
        accept    = bus.REQ_FAIL | bus.REQ_READ | bus.REQ_WRITE;
        sel_frame = {32'h4F4B0D0A, 88'h0};
        sel_count = 4'd4;
        if (bus.REQ_FAIL) begin
            sel_frame = {32'h45520D0A, 88'h0};
            sel_count = 4'd4;
        end else if (bus.REQ_READ) begin
            sel_frame = {8'h44, 8'h20, bus.REQ_ADDR, 8'h20,
                         hex(bus.RD_DATA[31:28]), hex(bus.RD_DATA[27:24]),
                         hex(bus.RD_DATA[23:20]), hex(bus.RD_DATA[19:16]),
                         hex(bus.RD_DATA[15:12]), hex(bus.RD_DATA[11:8]),
                         hex(bus.RD_DATA[7:4]),   hex(bus.RD_DATA[3:0]),
                         8'h0D, 8'h0A};
            sel_count = 4'd15;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            frame       <= '0;
            count       <= '0;
            tcnt        <= '0;
            tx_data     <= 8'h00;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        frame    <= sel_frame;
                        count    <= sel_count;
                        tx_data  <= sel_frame[119:112];
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    tcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // TX_DONE on the last allowed cycle still wins over the abort.
                    if (bus.TX_DONE) begin
                        frame <= frame << 8;
                        count <= count - 4'd1;
                        if (count > 4'd1) begin
                            tx_data  <= frame[111:104];
                            tx_start <= 1'b1;
                            state    <= SEND;
                        end else begin
                            state <= FINISH;
                        end
                    end else if (tcnt == DONE_TIMEOUT - 16'd1) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        frame       <= '0;
                        count       <= '0;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                FINISH: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.TX_DATA     = tx_data;
    assign bus.TX_START    = tx_start;
    assign bus.BUSY        = busy;
    assign bus.FRAME_DONE  = frame_done;
    assign bus.TIMEOUT_ERR = timeout_err;
    assign fsm_state       = state;
endmodule

// File: tb/tb_uart_pro_tx.sv
// Directed bench for uart_pro_tx: a byte-transmitter responder with programmable
// TX_DONE latency records every transmitted byte; each scenario task checks its own results.
module tb_uart_pro_tx;
    logic       CLK;
    logic       RST;
    logic [1:0] fsm_state;

    uart_pro_tx_if tx_if ();

    uart_pro_tx #(.DONE_TIMEOUT(16'd8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (tx_if),
        .fsm_state (fsm_state)
    );

    int compared   = 0;
    int mismatched = 0;

    int         cyc        = 0;
    int         target_cyc = -1;
    int         done_delay = 1;
    logic [7:0] got_q[$];
    int         start_q[$];
    int         fd_cnt     = 0;
    int         fd_cyc     = 0;
    logic       busy_at_fd = 1'b1;
    int         to_cnt     = 0;
    int         to_cyc     = 0;
    logic       busy_at_to = 1'b1;
    int         unstable   = 0;
    logic       in_flight  = 1'b0;
    logic [7:0] held       = 8'h00;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Responder/monitor samples 1 time unit after each rising edge.
    always @(posedge CLK) begin
        #1;
        cyc++;
        if (!RST) begin
            target_cyc    = -1;
            in_flight     = 1'b0;
            tx_if.TX_DONE = 1'b0;
        end else begin
            if (tx_if.TX_START) begin
                got_q.push_back(tx_if.TX_DATA);
                start_q.push_back(cyc);
                held       = tx_if.TX_DATA;
                in_flight  = 1'b1;
                target_cyc = (done_delay > 0) ? cyc + done_delay : -1;
            end else if (in_flight && tx_if.TX_DATA !== held) begin
                unstable++;
            end
            tx_if.TX_DONE = (target_cyc == cyc);
            if (tx_if.TX_DONE) in_flight = 1'b0;
            if (tx_if.FRAME_DONE) begin
                fd_cnt++;
                fd_cyc     = cyc;
                busy_at_fd = tx_if.BUSY;
            end
            if (tx_if.TIMEOUT_ERR) begin
                to_cnt++;
                to_cyc     = cyc;
                busy_at_to = tx_if.BUSY;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic clear_log();
        got_q.delete();
        start_q.delete();
        fd_cnt   = 0;
        to_cnt   = 0;
        unstable = 0;
    endtask

    task automatic pulse_req(input logic rd, input logic wr, input logic fl,
                             input logic [15:0] addr, input logic [31:0] data,
                             output int acc_cyc);
        tx_if.REQ_READ  = rd;
        tx_if.REQ_WRITE = wr;
        tx_if.REQ_FAIL  = fl;
        tx_if.REQ_ADDR  = addr;
        tx_if.RD_DATA   = data;
        acc_cyc = cyc;
        tick();
        tx_if.REQ_READ  = 1'b0;
        tx_if.REQ_WRITE = 1'b0;
        tx_if.REQ_FAIL  = 1'b0;
        tx_if.REQ_ADDR  = 16'hFFFF;
        tx_if.RD_DATA   = 32'hFFFF_FFFF;
    endtask

    task automatic wait_end(input int budget, output bit seen);
        int base;
        base = fd_cnt + to_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (fd_cnt + to_cnt > base) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic check_bytes(input string name, input logic [7:0] exp_q[$], input int offset);
        for (int i = 0; i < exp_q.size(); i++) begin
            compared++;
            if (i + offset >= got_q.size() || got_q[i + offset] !== exp_q[i]) begin
                mismatched++;
                $display("FAIL %s byte %0d: got %h expected %h", name, i + offset,
                         (i + offset < got_q.size()) ? got_q[i + offset] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        tick();
        tick();
        compared++;
        if ({tx_if.TX_DATA, tx_if.TX_START, tx_if.BUSY, tx_if.FRAME_DONE, tx_if.TIMEOUT_ERR, fsm_state} !== 14'h0) begin
            mismatched++;
            $display("FAIL reset_outputs: got data=%h start=%b busy=%b fd=%b to=%b st=%0d expected all 0",
                     tx_if.TX_DATA, tx_if.TX_START, tx_if.BUSY, tx_if.FRAME_DONE, tx_if.TIMEOUT_ERR, fsm_state);
        end
        RST = 1'b1;
        tick();
    endtask

    task automatic test_read_frame();
        int acc;
        bit seen;
        logic [7:0] exp_q[$];
        exp_q = '{8'h44, 8'h20, 8'h31, 8'h46, 8'h20, 8'h44, 8'h45, 8'h41,
                  8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        clear_log();
        done_delay = 3;
        pulse_req(1'b1, 1'b0, 1'b0, 16'h3146, 32'hDEADBEEF, acc);
        compared++;
        if (tx_if.BUSY !== 1'b1) begin
            mismatched++;
            $display("FAIL read_busy_after_accept: got %b expected 1", tx_if.BUSY);
        end
        wait_end(200, seen);
        compared++;
        if (seen !== 1'b1) begin
            mismatched++;
            $display("FAIL read_end_timeout: got no frame end, expected one within 200 cycles");
        end
        compared++;
        if (got_q.size() !== 15) begin
            mismatched++;
            $display("FAIL read_len: got %0d expected 15", got_q.size());
        end
        check_bytes("read", exp_q, 0);
        compared++;
        if (fd_cnt !== 1 || busy_at_fd !== 1'b0 || to_cnt !== 0 || unstable !== 0) begin
            mismatched++;
            $display("FAIL read_status: got fd=%0d busy@fd=%b to=%0d unstable=%0d expected 1 0 0 0",
                     fd_cnt, busy_at_fd, to_cnt, unstable);
        end
    endtask

    task automatic test_busy_drop();
        int acc;
        bit seen;
        logic [7:0] exp_q[$];
        exp_q = '{8'h4F, 8'h4B, 8'h0D, 8'h0A, 8'h44};
        clear_log();
        done_delay = 2;
        pulse_req(1'b0, 1'b1, 1'b0, 16'h0000, 32'h0, acc);
        tick();
        tick();
        pulse_req(1'b1, 1'b0, 1'b0, 16'h3232, 32'h11111111, acc);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tx_if.FRAME_DONE) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        compared++;
        if (seen !== 1'b1) begin
            mismatched++;
            $display("FAIL busy_first_end: got no FRAME_DONE, expected one within 100 cycles");
        end
        compared++;
        if (got_q.size() !== 4) begin
            mismatched++;
            $display("FAIL busy_drop_len: got %0d bytes expected 4", got_q.size());
        end
        pulse_req(1'b1, 1'b0, 1'b0, 16'h3939, 32'h0, acc);
        wait_end(200, seen);
        compared++;
        if (seen !== 1'b1 || fd_cnt !== 2 || got_q.size() !== 19) begin
            mismatched++;
            $display("FAIL busy_fd_accept: got seen=%b fd=%0d bytes=%0d expected 1 2 19", seen, fd_cnt, got_q.size());
        end
        check_bytes("busy", exp_q, 0);
    endtask

    task automatic test_priority();
        int acc;
        bit seen;
        logic [7:0] exp_q[$];
        exp_q = '{8'h45, 8'h52, 8'h0D, 8'h0A};
        clear_log();
        done_delay = 1;
        pulse_req(1'b1, 1'b1, 1'b1, 16'h3131, 32'h12345678, acc);
        wait_end(100, seen);
        tick();
        tick();
        compared++;
        if (seen !== 1'b1 || fd_cnt !== 1 || got_q.size() !== 4) begin
            mismatched++;
            $display("FAIL prio_frame: got seen=%b fd=%0d bytes=%0d expected 1 1 4", seen, fd_cnt, got_q.size());
        end
        check_bytes("prio", exp_q, 0);
    endtask

    task automatic test_timeout();
        int acc;
        bit seen;
        clear_log();
        done_delay = 0;
        pulse_req(1'b1, 1'b0, 1'b0, 16'h3146, 32'hDEADBEEF, acc);
        wait_end(50, seen);
        repeat (5) tick();
        compared++;
        if (seen !== 1'b1 || to_cnt !== 1 || fd_cnt !== 0) begin
            mismatched++;
            $display("FAIL to_event: got seen=%b to=%0d fd=%0d expected 1 1 0", seen, to_cnt, fd_cnt);
        end
        compared++;
        if (got_q.size() !== 1 || start_q.size() !== 1) begin
            mismatched++;
            $display("FAIL to_starts: got %0d expected 1", got_q.size());
        end else begin
            compared++;
            if (got_q[0] !== 8'h44 || to_cyc - start_q[0] !== 9) begin
                mismatched++;
                $display("FAIL to_timing: got data=%h delay=%0d expected 44 9", got_q[0], to_cyc - start_q[0]);
            end
        end
        compared++;
        if (busy_at_to !== 1'b0 || tx_if.BUSY !== 1'b0 || fsm_state !== 2'd0) begin
            mismatched++;
            $display("FAIL to_idle: got busy@to=%b busy=%b st=%0d expected 0 0 0", busy_at_to, tx_if.BUSY, fsm_state);
        end
        clear_log();
        done_delay = 8;
        pulse_req(1'b1, 1'b0, 1'b0, 16'h3146, 32'hDEADBEEF, acc);
        wait_end(300, seen);
        compared++;
        if (seen !== 1'b1 || fd_cnt !== 1 || to_cnt !== 0 || got_q.size() !== 15) begin
            mismatched++;
            $display("FAIL to_edge_done: got seen=%b fd=%0d to=%0d bytes=%0d expected 1 1 0 15",
                     seen, fd_cnt, to_cnt, got_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        bit seen;
        logic [7:0] exp_q[$];
        exp_q = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
        clear_log();
        done_delay = 3;
        pulse_req(1'b1, 1'b0, 1'b0, 16'h3146, 32'hDEADBEEF, acc);
        for (int i = 0; i < 100 && got_q.size() < 3; i++) tick();
        tick();
        RST = 1'b0;
        #1;
        compared++;
        if ({tx_if.TX_DATA, tx_if.TX_START, tx_if.BUSY, tx_if.FRAME_DONE, tx_if.TIMEOUT_ERR} !== 12'h0) begin
            mismatched++;
            $display("FAIL rst_mid_outputs: got data=%h start=%b busy=%b fd=%b to=%b expected all 0",
                     tx_if.TX_DATA, tx_if.TX_START, tx_if.BUSY, tx_if.FRAME_DONE, tx_if.TIMEOUT_ERR);
        end
        tick();
        tick();
        RST = 1'b1;
        repeat (10) tick();
        compared++;
        if (got_q.size() !== 3 || fd_cnt !== 0) begin
            mismatched++;
            $display("FAIL rst_no_partial: got bytes=%0d fd=%0d expected 3 0", got_q.size(), fd_cnt);
        end
        clear_log();
        pulse_req(1'b0, 1'b1, 1'b0, 16'h0000, 32'h0, acc);
        wait_end(100, seen);
        compared++;
        if (seen !== 1'b1 || got_q.size() !== 4) begin
            mismatched++;
            $display("FAIL rst_restart: got seen=%b bytes=%0d expected 1 4", seen, got_q.size());
        end
        check_bytes("rst_restart", exp_q, 0);
    endtask

    task automatic test_back_to_back();
        int acc;
        bit seen;
        int bad_gap;
        logic [7:0] exp_q[$];
        exp_q = '{8'h44, 8'h20, 8'h30, 8'h30, 8'h20, 8'h30, 8'h31, 8'h32,
                  8'h33, 8'h41, 8'h30, 8'h43, 8'h46, 8'h0D, 8'h0A};
        clear_log();
        done_delay = 1;
        pulse_req(1'b1, 1'b0, 1'b0, 16'h3030, 32'h0123A0CF, acc);
        wait_end(100, seen);
        compared++;
        if (seen !== 1'b1 || fd_cnt !== 1 || fd_cyc - acc !== 32) begin
            mismatched++;
            $display("FAIL b2b_latency: got seen=%b fd=%0d latency=%0d expected 1 1 32", seen, fd_cnt, fd_cyc - acc);
        end
        check_bytes("b2b", exp_q, 0);
        bad_gap = 0;
        for (int i = 1; i < start_q.size(); i++)
            if (start_q[i] - start_q[i-1] != 2) bad_gap++;
        compared++;
        if (start_q.size() !== 15 || bad_gap !== 0 || start_q[0] - acc !== 1) begin
            mismatched++;
            $display("FAIL b2b_spacing: got starts=%0d bad_gaps=%0d first=%0d expected 15 0 1",
                     start_q.size(), bad_gap, start_q.size() > 0 ? start_q[0] - acc : -1);
        end
    endtask

    initial begin
        RST             = 1'b0;
        tx_if.REQ_READ  = 1'b0;
        tx_if.REQ_WRITE = 1'b0;
        tx_if.REQ_FAIL  = 1'b0;
        tx_if.REQ_ADDR  = 16'h0000;
        tx_if.RD_DATA   = 32'h0;
        tx_if.TX_DONE   = 1'b0;
        test_reset();
        test_read_frame();
        test_busy_drop();
        test_priority();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
